// File: rtl/led_pattern_sequencer_pkg.sv
// Shared definitions for the rotating-pattern LED sequencer.
package led_pattern_sequencer_pkg;

  // Run-control state encoding.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  // Board configuration: 3 channels of 10-bit patterns, 8-bit prescaler.
  localparam int LSEQ_NUM_CH = 3;
  localparam int LSEQ_PAT_W  = 10;
  localparam int LSEQ_DIV_W  = 8;

  // Power-up patterns; channel i occupies bits [i*10 +: 10].
  localparam logic [LSEQ_NUM_CH*LSEQ_PAT_W-1:0] LSEQ_DEFAULT_PAT =
    {10'b1010101000, 10'b0110101100, 10'b0010011110};

endpackage

// File: rtl/led_pattern_sequencer_step_tick_gen.sv
// Step prescaler: emits a one-cycle tick every div+1 enabled cycles.
// The count holds while en is low so a paused run resumes where it stopped.
module led_pattern_sequencer_step_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == i_div);

  // Count 0..div while enabled, restarting from zero after each tick or on clear.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Rotating-pattern LED sequencer: a cfg bank written through a valid/ready
// port, a work bank that rotates one bit per step, and a start/stop/pause FSM.
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int                          NUM_CH      = LSEQ_NUM_CH,
  parameter int                          PAT_W       = LSEQ_PAT_W,
  parameter int                          DIV_W       = LSEQ_DIV_W,
  parameter logic [NUM_CH*PAT_W-1:0]     DEFAULT_PAT = LSEQ_DEFAULT_PAT,
  localparam int                         CH_W        = $clog2(NUM_CH),
  localparam int                         STEP_W      = $clog2(PAT_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_pause,
  input  logic              i_oneshot,
  input  logic              i_dir,
  input  logic [DIV_W-1:0]  i_div,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [PAT_W-1:0]  i_cfg_pat,
  output logic [NUM_CH-1:0] o_led,
  output logic              o_busy,
  output logic              o_done,
  output logic [STEP_W-1:0] o_step_idx,
  output state_t            o_dbg_state
);

  state_t              r_state;
  logic [DIV_W-1:0]    r_div;
  logic                r_dir;
  logic                r_oneshot;
  logic [NUM_CH-1:0]   r_led;
  logic                r_done;
  logic [STEP_W-1:0]   r_step_idx;

  logic                w_start_acc;
  logic                w_cfg_we;
  logic                w_tick_en;
  logic                w_tick;
  logic [NUM_CH-1:0]   w_led_next;

  // Config handshake: a write transfers on any edge where i_cfg_valid and
  // o_cfg_ready are both high; ready is high only while IDLE, and the master
  // holds valid/ch/pat stable until the transfer. Out-of-range channel writes
  // transfer but update no channel.
  assign o_cfg_ready = (r_state == S_IDLE);
  assign w_cfg_we    = i_cfg_valid && o_cfg_ready;

  // stop and pause both outrank start.
  assign w_start_acc = (r_state == S_IDLE) && i_start && !i_stop && !i_pause;
  assign w_tick_en   = (r_state == S_RUN) && !i_stop && !i_pause;

  led_pattern_sequencer_step_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_tick_en),
    .i_clr  (w_start_acc),
    .i_div  (r_div),
    .o_tick (w_tick)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [PAT_W-1:0] r_cfg;
    logic [PAT_W-1:0] r_work;
    logic             w_hit;

    assign w_hit         = w_cfg_we && (i_cfg_ch == CH_W'(g));
    assign w_led_next[g] = r_dir ? r_work[PAT_W-1] : r_work[0];

    // Config bank: updated only by an accepted write addressed to this channel.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_cfg <= DEFAULT_PAT[g*PAT_W +: PAT_W];
      end else if (w_hit) begin
        r_cfg <= i_cfg_pat;
      end
    end

    // Work bank: loaded at start (seeing a same-edge write), rotated on each tick.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_work <= DEFAULT_PAT[g*PAT_W +: PAT_W];
      end else if (w_start_acc) begin
        r_work <= w_hit ? i_cfg_pat : r_cfg;
      end else if (w_tick) begin
        r_work <= r_dir ? {r_work[PAT_W-2:0], r_work[PAT_W-1]}
                        : {r_work[0], r_work[PAT_W-1:1]};
      end
    end
  end

  // Run-control FSM with registered led, step index and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_dir      <= 1'b0;
      r_oneshot  <= 1'b0;
      r_led      <= '0;
      r_done     <= 1'b0;
      r_step_idx <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_acc) begin
            r_state    <= S_RUN;
            r_div      <= i_div;
            r_dir      <= i_dir;
            r_oneshot  <= i_oneshot;
            r_step_idx <= '0;
          end
        end
        S_RUN: begin
          if (i_stop) begin
            r_state    <= S_IDLE;
            r_led      <= '0;
            r_step_idx <= '0;
          end else if (i_pause) begin
            r_state <= S_PAUSE;
          end else if (w_tick) begin
            r_led <= w_led_next;
            if (r_step_idx == STEP_W'(PAT_W - 1)) begin
              r_step_idx <= '0;
              if (r_oneshot) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end
            end else begin
              r_step_idx <= r_step_idx + STEP_W'(1);
            end
          end
        end
        S_PAUSE: begin
          if (i_stop) begin
            r_state    <= S_IDLE;
            r_led      <= '0;
            r_step_idx <= '0;
          end else if (!i_pause) begin
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_led       = r_led;
  assign o_busy      = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign o_done      = r_done;
  assign o_step_idx  = r_step_idx;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed runs, scoreboard of expected ticks.
module tb_led_pattern_sequencer;
  import led_pattern_sequencer_pkg::*;

  localparam int EW = 39;  // {cycle[31:0], step[3:0], led[2:0]}

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, pause, oneshot, dir;
  logic [7:0] div;
  logic       cfg_valid, cfg_ready;
  logic [1:0] cfg_ch;
  logic [9:0] cfg_pat;
  logic [2:0] led;
  logic       busy, done;
  logic [3:0] step_idx;
  state_t     dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  led_pattern_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (start),
    .i_stop      (stop),
    .i_pause     (pause),
    .i_oneshot   (oneshot),
    .i_dir       (dir),
    .i_div       (div),
    .i_cfg_valid (cfg_valid),
    .o_cfg_ready (cfg_ready),
    .i_cfg_ch    (cfg_ch),
    .i_cfg_pat   (cfg_pat),
    .o_led       (led),
    .o_busy      (busy),
    .o_done      (done),
    .o_step_idx  (step_idx),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            done_cnt = 0;
  logic [9:0]    tb_pat[3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_default_pats();
    tb_pat[0] = 10'b0010011110;
    tb_pat[1] = 10'b0110101100;
    tb_pat[2] = 10'b1010101000;
  endtask

  // LED word after the k-th tick (k from 1) of a run over tb_pat.
  function automatic logic [2:0] exp_led(input int k, input bit dr);
    int idx;
    logic [2:0] r;
    idx = (k - 1) % 10;
    for (int ch = 0; ch < 3; ch++)
      r[ch] = dr ? tb_pat[ch][9 - idx] : tb_pat[ch][idx];
    return r;
  endfunction

  task automatic push_tick(input int k, input int at_cycle, input bit dr);
    logic [31:0] c;
    logic [3:0]  s;
    c = at_cycle;
    s = 4'(k % 10);
    exp_q.push_back({c, s, exp_led(k, dr)});
  endtask

  // ---------------- monitor ----------------
  // A tick is visible as a step_idx change while running or on the done edge.
  logic [3:0] prev_step = 4'd0;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (step_idx != prev_step && (busy || done)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_tick: got step %0d led %b, expected no tick (cycle %0d)",
                 step_idx, led, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("tick_led", led, e[2:0]);
        chk("tick_step", step_idx, e[6:3]);
        chk("tick_cycle", cyc, e[38:7]);
      end
    end
    prev_step = step_idx;
  end

  always @(negedge clk) if (done) done_cnt++;

  // ---------------- driver tasks ----------------
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the start edge (cyc = c0).
  task automatic start_run(input int d, input bit dr, input bit os, input int n, output int c0);
    div     = 8'(d);
    dir     = dr;
    oneshot = os;
    start   = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    cfg_valid = 1'b0;
    c0 = cyc;
    for (int k = 1; k <= n; k++) push_tick(k, c0 + k * (d + 1), dr);
    // Run parameters are latched; scramble the live inputs.
    div     = 8'($urandom_range(0, 255));
    dir     = ~dr;
    oneshot = ~os;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [9:0] pat);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_pat   = pat;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_led"}, led, 3'b000);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_step"}, step_idx, 4'd0);
    chk({tag, "_cfg_ready"}, cfg_ready, 1'b1);
    chk({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    int d0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    oneshot = 1'b0; dir = 1'b0; div = 8'd0;
    cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_pat = 10'd0;
    set_default_pats();
    wait_n(2);
    chk_reset_outputs("reset");
    reset = 1'b0;
    wait_n(1);

    // 1: div=0 loop, right rotation, 12 ticks.
    d0 = done_cnt;
    start_run(0, 1'b0, 1'b0, 12, c0);
    wait_n(1); chk("t1_led_tick1", led, 3'b000);
    wait_n(1); chk("t1_led_tick2", led, 3'b001);
    wait_n(1); chk("t1_led_tick3", led, 3'b011);
    wait_n(9);
    do_stop();
    chk("t1_stop_led", led, 3'b000);
    chk("t1_stop_busy", busy, 1'b0);
    chk("t1_no_done", done_cnt - d0, 0);

    // 2: div=3 loop, 12 ticks, 4-cycle spacing and step wrap.
    start_run(3, 1'b0, 1'b0, 12, c0);
    wait_n(48);
    do_stop();

    // 3: one-shot, then replay.
    d0 = done_cnt;
    start_run(0, 1'b0, 1'b1, 10, c0);
    wait_n(9);
    chk("t3_busy_mid", busy, 1'b1);
    chk("t3_ready_mid", cfg_ready, 1'b0);
    chk("t3_done_mid", done, 1'b0);
    wait_n(1);
    chk("t3_done_pulse", done, 1'b1);
    chk("t3_busy_end", busy, 1'b0);
    chk("t3_ready_end", cfg_ready, 1'b1);
    chk("t3_led_hold", led, 3'b100);
    wait_n(1);
    chk("t3_done_clear", done, 1'b0);
    start_run(0, 1'b0, 1'b1, 10, c0);
    wait_n(11);
    chk("t3_done_count", done_cnt - d0, 2);

    // 4: config port.
    cfg_write(2'd3, 10'h000);
    cfg_write(2'd1, 10'h3FF);
    tb_pat[1] = 10'h3FF;
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_pat = 10'h001;
    tb_pat[0] = 10'h001;
    start_run(0, 1'b0, 1'b1, 10, c0);
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_pat = 10'h000;
    wait_n(1);
    chk("t4_ready_run", cfg_ready, 1'b0);
    chk("t4_led_tick1", led, 3'b011);
    wait_n(2);
    cfg_valid = 1'b0;
    wait_n(8);
    start_run(1, 1'b1, 1'b1, 10, c0);
    wait_n(21);

    // 5: pause with div=3, then stop while paused.
    d0 = done_cnt;
    start_run(3, 1'b0, 1'b0, 2, c0);
    wait_n(9);
    pause = 1'b1;
    wait_n(1);
    chk("t5_state_pause", dbg_state, S_PAUSE);
    chk("t5_busy_pause", busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_n(1);
      chk("t5_led_frozen", led, exp_led(2, 1'b0));
      chk("t5_step_frozen", step_idx, 4'd2);
    end
    pause = 1'b0;
    push_tick(3, c0 + 18, 1'b0);
    wait_n(5);
    pause = 1'b1;
    wait_n(2);
    stop = 1'b1;
    wait_n(1);
    stop = 1'b0;
    pause = 1'b0;
    chk("t5_stop_led", led, 3'b000);
    chk("t5_stop_busy", busy, 1'b0);
    chk("t5_stop_step", step_idx, 4'd0);
    chk("t5_stop_state", dbg_state, S_IDLE);
    chk("t5_no_done", done_cnt - d0, 0);

    // 6: reset, left rotation, mid-run reset restores defaults.
    reset = 1'b1;
    wait_n(1);
    reset = 1'b0;
    set_default_pats();
    chk_reset_outputs("t6_reset");
    start_run(0, 1'b1, 1'b0, 3, c0);
    wait_n(1); chk("t6_led_left1", led, 3'b100);
    wait_n(1); chk("t6_led_left2", led, 3'b010);
    wait_n(1);
    do_stop();
    cfg_write(2'd0, 10'h3FF);
    tb_pat[0] = 10'h3FF;
    start_run(0, 1'b0, 1'b0, 4, c0);
    wait_n(4);
    reset = 1'b1;
    wait_n(1);
    reset = 1'b0;
    set_default_pats();
    chk_reset_outputs("t6_midrun_reset");
    start_run(0, 1'b0, 1'b1, 10, c0);
    wait_n(12);

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
